ds2431_mem_cmd_dispatcher: RTL and testbench

Sequencer for the DS2431 memory-function layer. After the ROM-function layer hands over, it receives the memory command byte over the shared 1-Wire byte engine, decodes it, and launches one of the four memory-command blocks: Write Scratchpad, Read Scratchpad, Copy Scratchpad or Read Memory. While that command runs, the dispatcher gives it exclusive use of the byte engine. It then reports completion or failure upward, and aborts cleanly on a 1-Wire bus reset or a stalled transfer.

---
 rtl/ds2431_mem_pkg.sv | 44 ++++
 rtl/ds2431_mem_watchdog.sv | 32 +++
 rtl/ds2431_mem_cmd_dispatcher.sv | 144 ++++++++++++++
 tb/tb_ds2431_mem_cmd_dispatcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ds2431_mem_pkg.sv
// Shared opcodes, command indices, sequencer states and opcode decoder for the
// DS2431 memory-function dispatcher.
package ds2431_mem_pkg;

  localparam logic [7:0] OP_WS = 8'h0F;
  localparam logic [7:0] OP_RS = 8'hAA;
  localparam logic [7:0] OP_CS = 8'h55;
  localparam logic [7:0] OP_RM = 8'hF0;

  localparam logic [1:0] IDX_WS = 2'd0;
  localparam logic [1:0] IDX_RS = 2'd1;
  localparam logic [1:0] IDX_CS = 2'd2;
  localparam logic [1:0] IDX_RM = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RX_CMD,
    WAIT_BYTE,
    DECODE,
    LAUNCH,
    RUN,
    FINISH
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } decode_t;

  function automatic decode_t decode_op(input logic [7:0] op);
    decode_t d;
    d.legal = 1'b1;
    d.idx   = IDX_WS;
    case (op)
      OP_WS:   d.idx = IDX_WS;
      OP_RS:   d.idx = IDX_RS;
      OP_CS:   d.idx = IDX_CS;
      OP_RM:   d.idx = IDX_RM;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ds2431_mem_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle that completes TIMEOUT_CYCLES consecutive idle cycles.
module ds2431_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_W'(1);
    end
  end

  // The counter shows the number of idle cycles already elapsed, so the
  // TIMEOUT_CYCLES-th one is the cycle in which it still reads LAST.
  assign expire = en && !clr && (count == LAST);

endmodule

// File: rtl/ds2431_mem_cmd_dispatcher.sv
// Memory-function sequencer: receives the command byte, launches the matching
// command block, lends it the byte engine and reports the outcome upward.
module ds2431_mem_cmd_dispatcher
  import ds2431_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       memCmdTrig,
  input  logic       busReset,
  input  logic [7:0] receiveDat,
  input  logic       ByteTransDone,
  output logic       transTrig,
  output logic       nRxTx,
  input  logic [3:0] subTransTrig,
  input  logic [3:0] subNRxTx,
  output logic [3:0] cmdRunTrig,
  input  logic [3:0] cmdDone,
  input  logic [3:0] cmdFailed,
  output logic       cmdAbort,
  output logic [1:0] activeCmd,
  output logic       busy,
  output logic       memDone,
  output logic       memFailed
);

  state_t     state, state_nxt;
  logic       btdQ;
  logic       byteDone;
  logic [7:0] opReg;
  logic       fail, fail_nxt;
  decode_t    dec;
  logic       wd_clr, wd_en, wd_expire;

  assign byteDone = ByteTransDone & ~btdQ;
  assign dec      = decode_op(opReg);
  assign busy     = (state != IDLE);
  assign wd_en    = (state == RUN);
  assign wd_clr   = (state == LAUNCH) || ((state == RUN) && byteDone);

  ds2431_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk   (clk),
    .nRst  (nRst),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      btdQ      <= 1'b1;
      opReg     <= 8'h00;
      activeCmd <= 2'd0;
      fail      <= 1'b0;
    end else begin
      state <= state_nxt;
      btdQ  <= ByteTransDone;
      fail  <= fail_nxt;
      if ((state == WAIT_BYTE) && byteDone) begin
        opReg <= receiveDat;
      end
      if ((state == DECODE) && dec.legal) begin
        activeCmd <= dec.idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    fail_nxt   = fail;
    transTrig  = 1'b0;
    nRxTx      = 1'b0;
    cmdRunTrig = 4'b0000;
    cmdAbort   = 1'b0;
    memDone    = 1'b0;
    memFailed  = 1'b0;
    case (state)
      IDLE: begin
        if (memCmdTrig) begin
          state_nxt = RX_CMD;
          fail_nxt  = 1'b0;
        end
      end
      RX_CMD: begin
        transTrig = 1'b1;
        state_nxt = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (byteDone) state_nxt = DECODE;
      end
      DECODE: begin
        if (dec.legal) begin
          state_nxt = LAUNCH;
        end else begin
          state_nxt = FINISH;
          fail_nxt  = 1'b1;
        end
      end
      LAUNCH: begin
        cmdRunTrig = 4'b0001 << activeCmd;
        state_nxt  = RUN;
      end
      RUN: begin
        // Only the launched block reaches the engine; other requests are dropped.
        transTrig = subTransTrig[activeCmd];
        nRxTx     = subNRxTx[activeCmd];
        if (wd_expire) begin
          cmdAbort  = 1'b1;
          state_nxt = FINISH;
          fail_nxt  = 1'b1;
        end else if (cmdFailed[activeCmd]) begin
          state_nxt = FINISH;
          fail_nxt  = 1'b1;
        end else if (cmdDone[activeCmd]) begin
          state_nxt = FINISH;
          fail_nxt  = 1'b0;
        end
      end
      FINISH: begin
        memDone   = ~fail;
        memFailed = fail;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A bus reset outranks everything; the ROM layer restarts the sequence,
    // so no completion status is reported.
    if ((state != IDLE) && busReset) begin
      state_nxt  = IDLE;
      cmdAbort   = 1'b1;
      cmdRunTrig = 4'b0000;
      memDone    = 1'b0;
      memFailed  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ds2431_mem_cmd_dispatcher.sv
// Bench for the DS2431 memory command dispatcher: opcode table plus hand-built
// arbitration, watchdog and bus-reset sequences, with a completion scoreboard.
module tb_ds2431_mem_cmd_dispatcher;
  import ds2431_mem_pkg::*;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic       memCmdTrig = 1'b0;
  logic       busReset = 1'b0;
  logic [7:0] receiveDat = 8'h00;
  logic       ByteTransDone = 1'b1;
  logic       transTrig, nRxTx;
  logic [3:0] subTransTrig = 4'h0;
  logic [3:0] subNRxTx = 4'h0;
  logic [3:0] cmdRunTrig;
  logic [3:0] cmdDone = 4'h0;
  logic [3:0] cmdFailed = 4'h0;
  logic       cmdAbort;
  logic [1:0] activeCmd;
  logic       busy, memDone, memFailed;

  always #5 clk = ~clk;

  ds2431_mem_cmd_dispatcher #(
    .TIMEOUT_CYCLES(50),
    .TO_W          (17)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .memCmdTrig   (memCmdTrig),
    .busReset     (busReset),
    .receiveDat   (receiveDat),
    .ByteTransDone(ByteTransDone),
    .transTrig    (transTrig),
    .nRxTx        (nRxTx),
    .subTransTrig (subTransTrig),
    .subNRxTx     (subNRxTx),
    .cmdRunTrig   (cmdRunTrig),
    .cmdDone      (cmdDone),
    .cmdFailed    (cmdFailed),
    .cmdAbort     (cmdAbort),
    .activeCmd    (activeCmd),
    .busy         (busy),
    .memDone      (memDone),
    .memFailed    (memFailed)
  );

  localparam int ACT_DONE = 0;
  localparam int ACT_FAIL = 1;
  localparam int ACT_BOTH = 2;

  typedef struct {
    logic [7:0] op;
    int         act;
    logic       legal;
    logic [1:0] idx;
    logic       exp_fail;
  } vec_t;

  typedef struct {
    logic done;
    logic failed;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every memDone/memFailed must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (nRst && (memDone || memFailed)) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", {30'b0, memDone, memFailed}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_completion", {30'b0, memDone, memFailed}, {30'b0, mon_e.done, mon_e.failed});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drives trigger, command byte and engine edge; returns in the launch cycle.
  task automatic start_cmd(input logic [7:0] op, input logic legal, input logic [1:0] idx,
                           input string tag);
    cyc(); memCmdTrig = 1'b1;
    #1 chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    cyc(); memCmdTrig = 1'b0;
    #1 chk({tag, "_rx_trig"}, {29'b0, transTrig, nRxTx, busy}, 32'b101);
    cyc(); ByteTransDone = 1'b0;
    #1 chk({tag, "_wait_trig"}, {31'b0, transTrig}, 32'd0);
    cyc(); ByteTransDone = 1'b1; receiveDat = op;
    if (!legal) sb.push_back('{1'b0, 1'b1});
    cyc();
    #1 chk({tag, "_decode_norun"}, {28'b0, cmdRunTrig}, 32'd0);
    cyc();
    #1 chk({tag, "_launch"}, {28'b0, cmdRunTrig}, legal ? (32'd1 << idx) : 32'd0);
    if (legal) chk({tag, "_active"}, {30'b0, activeCmd}, {30'b0, idx});
    else chk({tag, "_illegal_fail"}, {30'b0, memDone, memFailed}, 32'b01);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] other;
    start_cmd(v.op, v.legal, v.idx, tag);
    if (!v.legal) begin
      cyc();
      #1 chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    end else begin
      other = v.idx + 2'd1;
      cyc(); cmdDone[other] = 1'b1; cmdFailed[other] = 1'b1;
      #1 chk({tag, "_run_once"}, {28'b0, cmdRunTrig}, 32'd0);
      cyc(); cmdDone = 4'h0; cmdFailed = 4'h0;
      #1 chk({tag, "_foreign_ignored"}, {31'b0, busy}, 32'd1);
      cyc();
      if (v.act != ACT_FAIL) cmdDone[v.idx] = 1'b1;
      if (v.act != ACT_DONE) cmdFailed[v.idx] = 1'b1;
      sb.push_back('{!v.exp_fail, v.exp_fail});
      #1 chk({tag, "_no_abort"}, {31'b0, cmdAbort}, 32'd0);
      cyc(); cmdDone = 4'h0; cmdFailed = 4'h0;
      #1 chk({tag, "_result"}, {30'b0, memDone, memFailed}, {30'b0, !v.exp_fail, v.exp_fail});
      chk({tag, "_finish_busy"}, {31'b0, busy}, 32'd1);
      cyc();
      #1 chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout: bench still running, required completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = '{8'h55, ACT_DONE, 1'b1, 2'd2, 1'b0};
    vecs[1] = '{8'hA5, ACT_DONE, 1'b0, 2'd0, 1'b1};
    vecs[2] = '{8'h0F, ACT_BOTH, 1'b1, 2'd0, 1'b1};
    vecs[3] = '{8'hAA, ACT_DONE, 1'b1, 2'd1, 1'b0};
    vecs[4] = '{8'hF0, ACT_FAIL, 1'b1, 2'd3, 1'b1};
    vecs[5] = '{8'h00, ACT_DONE, 1'b0, 2'd0, 1'b1};
    vecs[6] = '{8'hFF, ACT_DONE, 1'b0, 2'd0, 1'b1};
    vecs[7] = '{8'hF0, ACT_DONE, 1'b1, 2'd3, 1'b0};
    vecs[8] = '{8'h0F, ACT_DONE, 1'b1, 2'd0, 1'b0};
    vecs[9] = '{8'hAA, ACT_FAIL, 1'b1, 2'd1, 1'b1};

    #2 nRst = 1'b0;
    repeat (3) cyc();
    #1 chk("reset_outputs",
           {17'b0, transTrig, nRxTx, cmdRunTrig, cmdAbort, activeCmd, busy, memDone, memFailed},
           32'd0);
    nRst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Engine arbitration while Read Memory runs
    cyc(); subTransTrig = 4'hF; subNRxTx = 4'hF;
    #1 chk("arb_idle_blocked", {30'b0, transTrig, nRxTx}, 32'd0);
    subTransTrig = 4'h0; subNRxTx = 4'h0;
    start_cmd(8'hF0, 1'b1, 2'd3, "arb");
    cyc(); subTransTrig = 4'b0001; subNRxTx = 4'b0001;
    #1 chk("arb_ws_dropped", {30'b0, transTrig, nRxTx}, 32'd0);
    cyc(); subTransTrig = 4'b1000; subNRxTx = 4'b1000;
    #1 chk("arb_rm_tx", {30'b0, transTrig, nRxTx}, 32'b11);
    subNRxTx = 4'b0000;
    #1 chk("arb_rm_rx", {30'b0, transTrig, nRxTx}, 32'b10);
    cyc(); subTransTrig = 4'h0; memCmdTrig = 1'b1; cmdDone[3] = 1'b1;
    sb.push_back('{1'b1, 1'b0});
    cyc(); memCmdTrig = 1'b0; cmdDone = 4'h0;
    #1 chk("arb_result", {30'b0, memDone, memFailed}, 32'b10);
    cyc();
    #1 chk("arb_trig_not_queued", {31'b0, busy}, 32'd0);
    cyc();
    #1 chk("arb_still_idle", {31'b0, busy}, 32'd0);

    // Stall watchdog: one byte completes in RUN cycle 20, restarting the count
    start_cmd(8'hAA, 1'b1, 2'd1, "wd");
    sb.push_back('{1'b0, 1'b1});
    for (int k = 1; k <= 70; k++) begin
      cyc(); ByteTransDone = (k == 19) ? 1'b0 : 1'b1;
      #1 chk($sformatf("wd_abort_c%0d", k), {31'b0, cmdAbort}, {31'b0, k == 70});
    end
    cyc();
    #1 chk("wd_failed", {29'b0, cmdAbort, memDone, memFailed}, 32'b001);
    cyc();
    #1 chk("wd_idle", {31'b0, busy}, 32'd0);

    // Bus reset: ignored in IDLE, aborts in WAIT_BYTE and in RUN
    cyc(); busReset = 1'b1;
    #1 chk("br_idle_ignored", {31'b0, cmdAbort}, 32'd0);
    cyc(); busReset = 1'b0; memCmdTrig = 1'b1;
    cyc(); memCmdTrig = 1'b0;
    #1 chk("br_rx_busy", {31'b0, busy}, 32'd1);
    cyc(); busReset = 1'b1;
    #1 chk("br_wait_abort", {31'b0, cmdAbort}, 32'd1);
    cyc(); busReset = 1'b0;
    #1 chk("br_wait_idle", {30'b0, busy, cmdAbort}, 32'd0);
    start_cmd(8'h55, 1'b1, 2'd2, "br2");
    cyc();
    cyc(); busReset = 1'b1;
    #1 chk("br_run_abort", {31'b0, cmdAbort}, 32'd1);
    cyc(); busReset = 1'b0;
    #1 chk("br_run_idle", {30'b0, busy, cmdAbort}, 32'd0);
    cyc();
    #1 chk("br_no_status", {30'b0, memDone, memFailed}, 32'd0);

    run_vec(vecs[0], "after_br");

    repeat (3) cyc();
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
